regfile_wb: RTL and testbench

- Architectural integer register file and the write-back end of the EX stage's write interface.
- Accepts the EX result triple (write enable, address, data) and serves two combinational read ports to ID, with same-cycle write-to-read bypass.
- Contains a busy-bit scoreboard: ID marks a destination pending at issue, write-back clears it, and stall_o tells ID to hold while an operand is still in flight.

---
 rtl/regfile_wb_pkg.sv | 23 ++
 rtl/reg_scoreboard.sv | 70 +++++++
 rtl/regfile_wb.sv | 89 ++++++++
 tb/tb_regfile_wb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// ============================================================================
// regfile_wb_pkg : shared widths and control constants for the register file
// Revision 1.0
// ============================================================================
`default_nettype none

package regfile_wb_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// reg_scoreboard : busy-bit tracking with flush/issue/clear priority
// Revision 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_enable,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              issue_enable,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  input  logic              r1_enable,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r2_enable,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic              r1_pending,
  output logic              r2_pending,
  output logic [ADDR_W:0]   busy_count
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [ADDR_W:0]     count_next;

  // Clear is applied before set so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wb_enable && (wb_addr != NOP_REG_ADDR)) busy_next[wb_addr] = 1'b0;
      if (issue_enable && (issue_addr != NOP_REG_ADDR)) busy_next[issue_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_next = count_next + {{ADDR_W{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

  // A write-back to the same register this cycle is forwarded, so no hazard.
  assign r1_pending = r1_enable && (r1_addr != NOP_REG_ADDR) && busy[r1_addr] &&
                      !(wb_enable && (wb_addr == r1_addr));
  assign r2_pending = r2_enable && (r2_addr != NOP_REG_ADDR) && busy[r2_addr] &&
                      !(wb_enable && (wb_addr == r2_addr));

endmodule

`default_nettype wire

// File: rtl/regfile_wb.sv
// ============================================================================
// regfile_wb : integer register file with write-back bypass and scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_enable_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              r1_enable_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  output logic [DATA_W-1:0] r1_data_o,
  input  logic              r2_enable_i,
  input  logic [ADDR_W-1:0] r2_addr_i,
  output logic [DATA_W-1:0] r2_data_o,
  input  logic              issue_enable_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [ADDR_W:0]   busy_count_o
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] r1_data;
  logic [DATA_W-1:0] r2_data;
  logic              r1_pending;
  logic              r2_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if ((w_enable_i == WRITE_ENABLE) && (w_addr_i != NOP_REG_ADDR)) begin
      regs[w_addr_i] <= w_data_i;
    end
  end

  always_comb begin
    r1_data = '0;
    if ((r1_enable_i == READ_ENABLE) && (r1_addr_i != NOP_REG_ADDR)) begin
      if (w_enable_i && (w_addr_i == r1_addr_i)) r1_data = w_data_i;
      else                                       r1_data = regs[r1_addr_i];
    end
  end

  always_comb begin
    r2_data = '0;
    if ((r2_enable_i == READ_ENABLE) && (r2_addr_i != NOP_REG_ADDR)) begin
      if (w_enable_i && (w_addr_i == r2_addr_i)) r2_data = w_data_i;
      else                                       r2_data = regs[r2_addr_i];
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_enable    (w_enable_i),
    .wb_addr      (w_addr_i),
    .issue_enable (issue_enable_i),
    .issue_addr   (issue_addr_i),
    .flush        (flush_i),
    .r1_enable    (r1_enable_i),
    .r1_addr      (r1_addr_i),
    .r2_enable    (r2_enable_i),
    .r2_addr      (r2_addr_i),
    .r1_pending   (r1_pending),
    .r2_pending   (r2_pending),
    .busy_count   (busy_count_o)
  );

  // Outputs are forced quiet while reset is held, even though bypass is combinational.
  assign r1_data_o = rst_n ? r1_data : '0;
  assign r2_data_o = rst_n ? r2_data : '0;
  assign stall_o   = rst_n & (r1_pending | r2_pending);

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb.sv
// ============================================================================
// tb_regfile_wb : directed and random checks of regfile_wb against a model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_enable;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        r1_enable;
  logic [4:0]  r1_addr;
  logic [31:0] r1_data;
  logic        r2_enable;
  logic [4:0]  r2_addr;
  logic [31:0] r2_data;
  logic        issue_enable;
  logic [4:0]  issue_addr;
  logic        flush;
  logic        stall;
  logic [5:0]  busy_count;

  int checks   = 0;
  int failures = 0;

  // Reference state: architectural values and outstanding destinations.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile_wb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .w_enable_i     (w_enable),
    .w_addr_i       (w_addr),
    .w_data_i       (w_data),
    .r1_enable_i    (r1_enable),
    .r1_addr_i      (r1_addr),
    .r1_data_o      (r1_data),
    .r2_enable_i    (r2_enable),
    .r2_addr_i      (r2_addr),
    .r2_data_o      (r2_data),
    .issue_enable_i (issue_enable),
    .issue_addr_i   (issue_addr),
    .flush_i        (flush),
    .stall_o        (stall),
    .busy_count_o   (busy_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
    if (!en || a == 0) return 32'h0;
    if (w_enable && w_addr == a) return w_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_pending(input logic en, input logic [4:0] a);
    return en && a != 0 && m_busy[a] && !(w_enable && w_addr == a);
  endfunction

  function automatic bit exp_stall();
    return exp_pending(r1_enable, r1_addr) || exp_pending(r2_enable, r2_addr);
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic idle();
    w_enable = 0; w_addr = 0; w_data = 0;
    r1_enable = 0; r1_addr = 0; r2_enable = 0; r2_addr = 0;
    issue_enable = 0; issue_addr = 0; flush = 0;
  endtask

  // Inputs are already applied at the falling edge; check, clock, update model.
  task automatic cycle(input string tag);
    #1;
    chk({tag, ".r1"}, r1_data, exp_read(r1_enable, r1_addr));
    chk({tag, ".r2"}, r2_data, exp_read(r2_enable, r2_addr));
    chk({tag, ".stall"}, {31'b0, stall}, {31'b0, exp_stall()});
    chk({tag, ".count"}, {26'b0, busy_count}, 32'(exp_count()));
    if (issue_enable) chk({tag, ".issue_no_stall"}, {31'b0, stall}, 32'h0);
    @(posedge clk);
    if (w_enable && w_addr != 0) m_regs[w_addr] = w_data;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (w_enable && w_addr != 0) m_busy[w_addr] = 1'b0;
      if (issue_enable && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    idle();
    rst_n = 0;
    w_enable = 1; w_addr = 4; w_data = 32'hAAAA5555;
    r1_enable = 1; r1_addr = 4; r2_enable = 1; r2_addr = 4;
    #3;
    chk("reset.r1", r1_data, 32'h0);
    chk("reset.r2", r2_data, 32'h0);
    chk("reset.stall", {31'b0, stall}, 32'h0);
    chk("reset.count", {26'b0, busy_count}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    idle();
    rst_n = 1;

    for (int i = 1; i < 32; i++) begin
      r1_enable = 1; r1_addr = 5'(i); r2_enable = 1; r2_addr = 5'(i);
      cycle("init_read");
    end

    idle();
    w_enable = 1; w_addr = 5; w_data = 32'hDEADBEEF; r1_enable = 1; r1_addr = 5;
    #1 chk("bypass_x5", r1_data, 32'hDEADBEEF);
    cycle("bypass");
    idle(); r1_enable = 1; r1_addr = 5;
    #1 chk("stored_x5", r1_data, 32'hDEADBEEF);
    cycle("stored");

    idle(); w_enable = 1; w_addr = 0; w_data = 32'h12345678;
    cycle("write_x0");
    idle(); r1_enable = 1; r2_enable = 1;
    cycle("read_x0");
    idle(); issue_enable = 1; issue_addr = 0;
    cycle("issue_x0");
    idle(); r1_enable = 1;
    #1 chk("x0_count", {26'b0, busy_count}, 32'h0);
    cycle("after_issue_x0");

    idle(); issue_enable = 1; issue_addr = 7;
    cycle("issue_x7");
    idle(); r2_enable = 1; r2_addr = 7;
    #1 chk("x7_stall", {31'b0, stall}, 32'h1);
    chk("x7_count", {26'b0, busy_count}, 32'h1);
    cycle("read_x7_busy");
    idle(); r2_enable = 1; r2_addr = 7; w_enable = 1; w_addr = 7; w_data = 32'h55;
    #1 chk("x7_wb_stall", {31'b0, stall}, 32'h0);
    chk("x7_wb_data", r2_data, 32'h55);
    cycle("wb_x7");
    idle();
    #1 chk("x7_count_clear", {26'b0, busy_count}, 32'h0);
    cycle("after_wb_x7");

    idle(); issue_enable = 1; issue_addr = 3; cycle("issue_x3");
    idle(); issue_enable = 1; issue_addr = 4; cycle("issue_x4");
    idle(); flush = 1; issue_enable = 1; issue_addr = 9; cycle("flush_issue_x9");
    idle(); r1_enable = 1; r1_addr = 3; r2_enable = 1; r2_addr = 4;
    #1 chk("flush_count", {26'b0, busy_count}, 32'h0);
    cycle("read_x3_x4");
    idle(); r1_enable = 1; r1_addr = 9;
    cycle("read_x9");
    idle(); issue_enable = 1; issue_addr = 6; w_enable = 1; w_addr = 6; w_data = 32'h66;
    cycle("issue_wb_x6");
    idle(); r1_enable = 1; r1_addr = 6;
    #1 chk("x6_still_busy", {31'b0, stall}, 32'h1);
    cycle("read_x6");

    // Random traffic concentrated on low registers to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      idle();
      w_enable   = ($urandom_range(0, 1) == 1);
      w_addr     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      w_data     = $urandom;
      r1_enable  = ($urandom_range(0, 3) != 0);
      r1_addr    = 5'($urandom_range(0, 7));
      r2_enable  = ($urandom_range(0, 3) != 0);
      r2_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 15) == 0);
      issue_addr = 5'($urandom_range(0, 8));
      issue_enable = !exp_stall() && ($urandom_range(0, 1) == 1);
      cycle("random");
    end

    // Asynchronous reset in the middle of a cycle with state outstanding.
    idle(); w_enable = 1; w_addr = 2; w_data = 32'hFF; cycle("write_x2");
    idle(); issue_enable = 1; issue_addr = 2; cycle("issue_x2");
    idle(); r1_enable = 1; r1_addr = 2; r2_enable = 1; r2_addr = 3;
    w_enable = 1; w_addr = 3; w_data = 32'hCAFE0001;
    #2 rst_n = 0;
    #1;
    chk("async_rst.r1", r1_data, 32'h0);
    chk("async_rst.r2", r2_data, 32'h0);
    chk("async_rst.stall", {31'b0, stall}, 32'h0);
    chk("async_rst.count", {26'b0, busy_count}, 32'h0);
    model_reset();
    @(negedge clk);
    idle();
    rst_n = 1;
    r1_enable = 1; r1_addr = 2;
    #1 chk("post_rst_x2", r1_data, 32'h0);
    cycle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
